// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: diff = x - y - bi, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  assign bo   = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             borrow;
  logic             cell_diff;
  logic             cell_bo;
  logic [WIDTH-1:0] acc_next;

  full_subtractor u_cell (
    .x    (op_a[0]),
    .y    (op_b[0]),
    .bi   (borrow),
    .diff (cell_diff),
    .bo   (cell_bo)
  );

  // Each new diff bit enters at the MSB so the LSB-first result ends up in place after WIDTH shifts.
  assign acc_next = {cell_diff, acc[WIDTH-1:1]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      b_out  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= b;
            borrow <= b_in;
            cnt    <= '0;
            acc    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          borrow <= cell_bo;
          acc    <= acc_next;
          cnt    <= cnt + 1'b1;
          // Final bit: publish the completed result; d never shows partial values.
          if (cnt == LAST) begin
            d     <= acc_next;
            b_out <= cell_bo;
            zero  <= (acc_next == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) using a scoreboard of expected results.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
  } exp_t;

  logic         clock;
  logic         resetn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
  logic         zero;

  exp_t sb[$];
  int   testsRun  = 0;
  int   testsFail = 0;
  int   busyRun   = 0;
  logic prevDone  = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .a      (a),
    .b      (b),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .d      (d),
    .b_out  (b_out),
    .zero   (zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: widen by one bit so the borrow appears as the sign bit.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] r;
    exp_t e;
    r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    e.d  = r[W-1:0];
    e.bo = r[W];
    e.z  = (r[W-1:0] == '0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Every done pulse pops one expected result; also checks pulse width and busy duration.
  always @(negedge clock) begin
    exp_t e;
    if (!resetn) begin
      busyRun  = 0;
      prevDone = 1'b0;
    end else begin
      if (done) begin
        checkOutput("done_width", int'(prevDone), 0);
        checkOutput("busy_len", busyRun, W);
        checkOutput("sb_pending", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("sb_d", int'(d), int'(e.d));
          checkOutput("sb_b_out", int'(b_out), int'(e.bo));
          checkOutput("sb_zero", int'(zero), int'(e.z));
        end
      end
      if (busy) busyRun++;
      else if (!done) busyRun = 0;
      prevDone = done;
    end
  end

  task automatic waitIdle();
    int n = 0;
    while ((busy || done) && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("idle_reached", int'(busy || done), 0);
  endtask

  task automatic waitDone(output int lat);
    int seen = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1;
        lat  = i;
        break;
      end
    end
    checkOutput("done_seen", seen, 1);
  endtask

  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int lat;
    waitIdle();
    start = 1'b1;
    a     = x;
    b     = y;
    b_in  = bi;
    sb.push_back(model(x, y, bi));
    @(posedge clock);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    b_in  = 1'($urandom);
    waitDone(lat);
    checkOutput("latency", lat, W + 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    resetn = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    b_in   = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_d", int'(d), 0);
    checkOutput("rst_b_out", int'(b_out), 0);
    checkOutput("rst_zero", int'(zero), 0);

    applyStimulus(4'd9, 4'd3, 1'b0);
    checkOutput("d_9_3", int'(d), 6);
    checkOutput("bo_9_3", int'(b_out), 0);
    applyStimulus(4'd3, 4'd9, 1'b0);
    checkOutput("d_3_9", int'(d), 10);
    checkOutput("bo_3_9", int'(b_out), 1);
    applyStimulus(4'd5, 4'd5, 1'b0);
    checkOutput("zero_5_5", int'(zero), 1);
    checkOutput("d_5_5", int'(d), 0);
    applyStimulus(4'd5, 4'd5, 1'b1);
    checkOutput("d_5_5_bin", int'(d), 15);
    checkOutput("bo_5_5_bin", int'(b_out), 1);
    checkOutput("zero_5_5_bin", int'(zero), 0);
    applyStimulus(4'd0, 4'd0, 1'b1);
    checkOutput("d_0_0_bin", int'(d), 15);
    checkOutput("bo_0_0_bin", int'(b_out), 1);

    // start held high: second op uses the operand value present when IDLE is re-entered
    waitIdle();
    start = 1'b1;
    a     = 4'd15;
    b     = 4'd1;
    b_in  = 1'b0;
    sb.push_back(model(4'd15, 4'd1, 1'b0));
    @(posedge clock);
    #1;
    @(negedge clock);
    a = 4'd0;
    sb.push_back(model(4'd0, 4'd1, 1'b0));
    waitDone(lat);
    checkOutput("held_d1", int'(d), 14);
    @(negedge clock);
    checkOutput("held_idle_busy", int'(busy), 0);
    @(negedge clock);
    checkOutput("held_second_busy", int'(busy), 1);
    checkOutput("held_d_hold", int'(d), 14);
    waitDone(lat);
    checkOutput("held_d2", int'(d), 15);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("held_no_third", int'(busy), 0);

    // reset in the middle of an operation
    applyStimulus(4'd9, 4'd3, 1'b0);
    waitIdle();
    start = 1'b1;
    a     = 4'd7;
    b     = 4'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("abort_busy_before", int'(busy), 1);
    checkOutput("abort_d_held", int'(d), 6);
    resetn = 1'b0;
    #1;
    checkOutput("abort_d", int'(d), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (8) @(negedge clock);
    checkOutput("abort_no_done", int'(done), 0);
    applyStimulus(4'd7, 4'd2, 1'b0);
    checkOutput("d_7_2", int'(d), 5);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++)
          applyStimulus(W'(i), W'(j), 1'(k));

    repeat (3) @(negedge clock);
    checkOutput("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor: computes a - b - b_in one bit per clock, LSB first, through a single full-subtractor cell.
It is the sequential, inverse-operation counterpart of the team's parallel ripple-carry adder.
It is intended for small datapaths where area matters more than latency.
It uses a start/busy/done handshake to sit behind a controller FSM.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..32)

Ports:
clock  in  1  system clock, rising-edge
resetn  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
a  in  WIDTH  minuend, captured on accepted start
b  in  WIDTH  subtrahend, captured on accepted start
b_in  in  1  borrow-in, captured on accepted start
busy  out  1  high while an operation is in progress (SHIFT state)
done  out  1  one-cycle pulse: result valid
d  out  WIDTH  difference, (a - b - b_in) mod 2^WIDTH
b_out  out  1  borrow-out; 1 iff a < b + b_in (unsigned)
zero  out  1  1 iff d == 0

Behaviour:
- Clock and reset: single clock domain.
  - clock and resetn (asynchronous, active-low) as already decided.
  - On resetn low: state=IDLE, bit counter=0, operand/borrow registers=0, busy=0, done=0, d=0, b_out=0, zero=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on start=1 at a rising edge.
    - Same edge captures a, b, b_in into internal shift registers.
    - Same edge clears the bit counter and the partial-result register.
  - SHIFT:
    - Each edge, the full-subtractor cell takes opA[0], opB[0] and the running borrow.
    - Its diff bit shifts into the result register MSB-side; operands shift right; the borrow register updates.
    - Counter increments.
    - After the WIDTH-th SHIFT edge: -> DONE; d, b_out and zero load from the completed result.
  - DONE -> IDLE unconditionally on the next edge.
- Outputs and latency:
  - busy = 1 exactly in SHIFT.
  - done = 1 exactly in DONE.
  - Accepted start at edge E0 -> done high for the one cycle following edge E0+WIDTH.
  - Next start can be accepted at edge E0+WIDTH+2.
- Result hold: d, b_out and zero are registered. They change only on entry to DONE and hold until the next completion or reset. Partial results are never visible on d.
- Input sampling:
  - start is ignored in SHIFT and DONE; there is no queuing.
  - a, b and b_in may change freely after the accepting edge.
- Arithmetic: WIDTH-bit unsigned, mod 2^WIDTH. b_in=1 with a=b gives d = all ones, b_out=1.
- Full-subtractor equations: diff = x ^ y ^ bi; bo = (~x & y) | (~x & bi) | (y & bi).
- Reset mid-operation: aborts immediately; all outputs return to reset values; no done pulse.
- Counter: width $clog2(WIDTH+1). No wrap-around is reachable because SHIFT exits at count == WIDTH-1.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH.
- One sub-module, full_subtractor (x, y, bi -> diff, bo): purely combinational, instantiated once.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- Test conditions: WIDTH=4. Check all outputs are 0 after reset release.
- a=9, b=3, b_in=0, start pulse -> busy high 4 cycles; done pulse at cycle 5 after start edge; d=6, b_out=0, zero=0.
- a=3, b=9, b_in=0 -> d=10 (4'b1010), b_out=1, zero=0.
- Borrow-in and zero-flag cases:
  - a=5, b=5, b_in=0 -> d=0, zero=1, b_out=0.
  - a=5, b=5, b_in=1 -> d=15, b_out=1, zero=0.
  - a=0, b=0, b_in=1 -> d=15, b_out=1.
- Start held high continuously with a=15, b=1:
  - First op gives d=14, done once.
  - start ignored while busy/done; second op accepted only in IDLE.
  - Change a to 0 mid-SHIFT -> result still 14.
- Reset and exhaustive checks:
  - Assert resetn low during 2nd SHIFT cycle (prior result d=6 held) -> d=0, busy=0, no done.
  - After release, a=7, b=2 -> d=5 normally.
- Exhaustive sweep of all a, b, b_in (512 ops) against a reference model; also check done width = 1 cycle and busy duration = 4.
